// File: rtl/counter_pkg.sv
// Shared helpers for counter and timebase blocks.
// Width derivation used by every counter instance.
package counter_pkg;

    // Bits needed to hold values 0..n-1 (at least one bit).
    function automatic int calc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/modulo_n_counter.sv
// Modulo-N up-counter with terminal-count strobe.
// tc of one stage drives en of the next in cascaded chains.
module modulo_n_counter
    import counter_pkg::*;
#(
    parameter  int N     = 10,
    localparam int WIDTH = calc_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // Reject a modulus with no states at elaboration.
    if (N < 1) begin : g_bad_n
        $error("modulo_n_counter: N must be >= 1");
    end

    // Terminal value held one bit wider so N = 2^WIDTH cannot overflow.
    localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(N - 1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   w_count_ext;
    logic             w_at_last;
    logic             w_wrap;

    assign w_count_ext = {1'b0, r_count};
    assign w_at_last   = (w_count_ext == LAST);
    // Unreachable states above N-1 also wrap, so the counter self-recovers.
    assign w_wrap      = (w_count_ext >= LAST);

    // Count register: reset wins, then wrap-or-increment while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (en) begin
            if (w_wrap) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign count = r_count;
    assign tc    = !rst && en && w_at_last;

endmodule

// File: tb/tb_modulo_n_counter.sv
// Scoreboard bench for modulo_n_counter at N = 10, 1, 8 and 5.
// Reference model uses plain modular arithmetic on integers.
module tb_modulo_n_counter;

    typedef struct {
        int cnt;
        bit tc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] en  = 4'b0000;

    logic [3:0] c10;
    logic [0:0] c1;
    logic [2:0] c8;
    logic [2:0] c5;
    logic       tc10, tc1, tc8, tc5;

    int   nmod [4] = '{10, 1, 8, 5};
    int   m    [4] = '{0, 0, 0, 0};
    exp_t q    [4][$];

    int errors   = 0;
    int checks   = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    modulo_n_counter #(.N(10)) u10 (
        .clk(clk), .rst(rst), .en(en[0]), .count(c10), .tc(tc10)
    );
    modulo_n_counter #(.N(1)) u1 (
        .clk(clk), .rst(rst), .en(en[1]), .count(c1), .tc(tc1)
    );
    modulo_n_counter #(.N(8)) u8 (
        .clk(clk), .rst(rst), .en(en[2]), .count(c8), .tc(tc8)
    );
    modulo_n_counter #(.N(5)) u5 (
        .clk(clk), .rst(rst), .en(en[3]), .count(c5), .tc(tc5)
    );

    // Next count: reset to 0, hold when idle, else advance modulo N.
    function automatic int nxt(input int cur, input int n,
                               input bit r, input bit e);
        if (r) return 0;
        if (!e) return cur;
        if (cur >= n) return 0;
        return (cur + 1) % n;
    endfunction

    // Drive inputs for the coming edge and record what the DUT shows now.
    task automatic apply(input bit r, input logic [3:0] e);
        exp_t x;
        rst = r;
        en  = e;
        for (int i = 0; i < 4; i++) begin
            if (checking) begin
                x.cnt = m[i];
                x.tc  = !r && e[i] && (m[i] == nmod[i] - 1);
                q[i].push_back(x);
            end
            m[i] = nxt(m[i], nmod[i], r, e[i]);
        end
    endtask

    task automatic step(input bit r, input logic [3:0] e);
        @(posedge clk);
        #1;
        apply(r, e);
    endtask

    task automatic run(input int k, input bit r, input bit e);
        for (int i = 0; i < k; i++) step(r, {4{e}});
    endtask

    // Monitor: compare the DUT against queued expectations each cycle.
    always @(posedge clk) begin : mon
        exp_t       x;
        logic [3:0] ac;
        logic       at;
        #3;
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() > 0) begin
                x = q[i].pop_front();
                case (i)
                    0:       begin ac = c10;          at = tc10; end
                    1:       begin ac = {3'b0, c1};   at = tc1;  end
                    2:       begin ac = {1'b0, c8};   at = tc8;  end
                    default: begin ac = {1'b0, c5};   at = tc5;  end
                endcase
                checks++;
                if (ac !== 4'(x.cnt)) begin
                    errors++;
                    $display("FAIL count N=%0d t=%0t got %0d want %0d",
                             nmod[i], $time, ac, x.cnt);
                end
                checks++;
                if (at !== x.tc) begin
                    errors++;
                    $display("FAIL tc N=%0d t=%0t got %b want %b",
                             nmod[i], $time, at, x.tc);
                end
            end
        end
    end

    initial begin
        // First edge: count is unknown beforehand, so nothing is queued.
        step(1'b1, 4'b0000);
        checking = 1'b1;

        // Reset with en low, then one idle edge.
        run(2, 1'b1, 1'b0);
        run(1, 1'b0, 1'b0);

        // Two full wraps.
        run(20, 1'b0, 1'b1);

        // Hold mid-count, then resume up to the terminal value.
        run(4, 1'b0, 1'b1);
        run(4, 1'b0, 1'b0);
        run(5, 1'b0, 1'b1);

        // Drop en at the terminal value, then raise it to wrap.
        run(2, 1'b0, 1'b0);
        run(1, 1'b0, 1'b1);

        // Reset in the middle of a count with en high.
        run(6, 1'b0, 1'b1);
        run(1, 1'b1, 1'b1);
        run(3, 1'b0, 1'b1);

        // Illegal state 6 in the N=5 counter must recover to 0.
        @(posedge clk);
        #1;
        force u5.r_count = 3'd6;
        #1;
        release u5.r_count;
        m[3] = 6;
        apply(1'b0, 4'b1111);
        run(2, 1'b0, 1'b1);

        // Randomised traffic.
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 15) == 0),
                 4'($urandom()) | 4'($urandom()));
        end

        run(1, 1'b0, 1'b0);
        @(posedge clk);
        #5;

        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q[i].size() != 0) begin
                errors++;
                $display("FAIL drain N=%0d left %0d want 0",
                         nmod[i], q[i].size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/modulo_n_counter.md
Name: modulo_n_counter

Overview:
- Synchronous up-counter that counts 0, 1, …, N-1 and then wraps to 0, advancing only while enabled.
- Provides a terminal-count strobe so instances can be cascaded into wider or multi-radix counters, e.g. decade/BCD chains, clock-enable prescalers and timebase generators.
- Used as a leaf utility block in sequential datapaths.

Parameters:
- N, 10, modulus (number of states); legal range N >= 1.
- WIDTH, derived localparam (not overridable): (N > 1) ? $clog2(N) : 1; width of count.

Ports:
- clk  input  1  rising-edge clock; only clock in the block.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; counter advances one state per clk edge while high.
- count  output  WIDTH  current counter state, registered, range 0..N-1.
- tc  output  1  terminal count; high while count == N-1 and en == 1.

Behaviour:
- Clocking and reset:
  - Single clock domain, all state updates on posedge clk.
  - Reset is synchronous and active-high; no asynchronous reset path.
  - Reset has priority over en. At a clk edge with rst=1, count <= 0 regardless of en.
  - tc is forced to 0 while rst=1, even for N=1.
- Counting:
  - At a clk edge with rst=0 and en=1: if count == N-1 then count <= 0, else count <= count + 1.
  - At a clk edge with rst=0 and en=0: count holds its value. There is no decay or reset on disable.
  - Latency: count changes on the first clk edge after en is sampled high. The state is visible one edge after the sample.
- Terminal count:
  - tc = !rst && en && (count == N-1). It is combinational from the registered count and the live en.
  - tc is high for exactly one clock cycle per wrap when en is held high continuously.
  - The edge at which tc=1 is the edge where count wraps to 0, so a downstream stage enabled by tc advances on the same edge.
  - Deasserting en while count == N-1 drops tc immediately and holds count at N-1. tc reasserts when en returns.
- Width and arithmetic:
  - count + 1 is computed in WIDTH+1 bits or compared before increment, so no overflow occurs when N is a power of two.
  - For N = 2^WIDTH the wrap is the natural rollover, but the explicit compare is still implemented.
  - States N..2^WIDTH-1 are unreachable from reset. If one is ever present (e.g. SEU, X-free sim forcing), the next enabled edge loads 0, so the counter self-recovers within one enabled cycle.
- Degenerate N=1:
  - WIDTH=1 and count is permanently 0.
  - tc = en && !rst, i.e. a divide-by-1 pass-through.
- Parameter check:
  - An elaboration-time check (generate-if with $error) rejects N < 1.
- Reset mid-operation:
  - Asserting rst at any count returns count to 0 on the next edge and clears tc in the same cycle.
  - Counting resumes from 0 on the first edge after rst deasserts, provided en=1.
- Simultaneous rst=1 and en=1: reset wins, count=0, tc=0.
- After power-up and before the first reset edge, count is X. The bench must apply rst for at least one edge.

Decomposition:
- Shared package (counter_pkg): function calc_width(int n) returning (n > 1) ? $clog2(n) : 1, reused by every counter and timebase block.
- No sub-module is warranted: a single always_ff for count plus one continuous assign for tc.
- Cascaded chains (e.g. modulo_n_counter x2 for 00..99) are built by instantiating this block at the parent level, with tc of stage k driving en of stage k+1.

Test Plan:
- Reset: N=10, rst=1 for 2 edges with en=0 -> count=0, tc=0. Then rst=0, en=0 for 1 edge -> count stays 0.
- Full sequence: N=10, en=1 for 20 edges -> count 0,1,…,9,0,…,9,0. tc=1 only in cycles where count=9 (exactly 2 pulses). Wrap 9->0 occurs on the tc edge.
- Hold: en=1 until count=4, en=0 for 4 edges -> count stays 4, tc=0. Then en=1 -> count 5,6,… continues without loss.
- Enable drop at terminal: reach count=9, drop en -> tc falls to 0 immediately, count holds 9. Raise en -> tc=1 that cycle, next edge count=0.
- Reset priority / mid-count: count=6, assert rst with en=1 -> next edge count=0, tc=0. Release -> 1,2,… from next edge.
- Parameter sweep: N=1 -> count always 0, tc follows en. N=8 (power of two, WIDTH=3) -> wraps 7->0 with tc at 7. N=5 -> force count=6 via bench force/release, one enabled edge -> count=0.
